unidad_busqueda: RTL
====================

Name: unidad_busqueda

Overview:
- Instruction-fetch unit: the initiator side of the instruction-memory read interface.
- Holds the program counter and drives the 6-bit instruction address to the combinational instruction memory. Captures the returned 32-bit word into a fetch register consumed by decode.
- Handles sequential increment, stall, jump/branch redirect with flush, and a halt word that freezes fetch until reset.

Parameters:
- ADDR_W, 6, instruction address width (64-word memory).
- DATA_W, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset.
- HALT_WORD, 32'hFFFFFFFF, encoding that stops fetch.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- stall  input  1  hold PC and fetch register (decode/hazard request).
- jump  input  1  unconditional redirect request.
- jump_target  input  ADDR_W  jump destination.
- branch_taken  input  1  taken-branch redirect request.
- branch_target  input  ADDR_W  branch destination.
- direinstru  output  ADDR_W  address to instruction memory; equals PC register.
- instru  input  DATA_W  word returned combinationally by instruction memory.
- instr_out  output  DATA_W  registered instruction for decode.
- pc_out  output  ADDR_W  address of instr_out.
- pc_plus1  output  ADDR_W  pc_out+1 mod 2^ADDR_W (link value); combinational from pc_out.
- valid_out  output  1  instr_out is a real instruction.
- halted  output  1  fetch frozen by HALT_WORD.

Behaviour:
- Single clock domain. All state updates on the rising edge of clk. rst_n is sampled only at the edge.
- Reset (rst_n=0 at an edge, in any state, mid-stall or mid-redirect):
  - pc=RESET_PC, instr_out=0, pc_out=0, valid_out=0, halted=0, state=FETCH.
  - direinstru therefore shows RESET_PC in the cycle after the reset edge.
- direinstru = pc, with no combinational path from any input. Memory read is combinational, so instru corresponding to pc is sampled at the same edge.
- FSM states: FETCH, HALT.
- FETCH priority per edge (highest first):
  1. Redirect (jump or branch_taken; applies even if stall=1):
     - pc <= jump ? jump_target : branch_target (jump wins when both asserted).
     - instr_out <= 0, valid_out <= 0 (flushes the wrong-path word), pc_out holds.
  2. Stall:
     - pc, instr_out, pc_out, valid_out all hold.
  3. instru == HALT_WORD:
     - instr_out <= instru, pc_out <= pc, valid_out <= 1.
     - pc holds; state <= HALT.
  4. Normal:
     - instr_out <= instru, pc_out <= pc, valid_out <= 1, pc <= pc+1.
- Fetch latency: one cycle. The word at address A appears on instr_out, with valid_out=1, one edge after direinstru=A.
- PC arithmetic is modulo 2^ADDR_W: 63+1 wraps to 0. Redirect targets are taken as-is (full ADDR_W range legal).
- HALT state:
  - First edge in HALT: valid_out <= 0, instr_out <= 0, halted <= 1. halted stays 1 thereafter.
  - pc and pc_out hold.
  - stall, jump and branch_taken are ignored. Only reset exits.
- A HALT_WORD fetched in the same cycle as a redirect is discarded (redirect priority), so HALT is not entered.
- A HALT_WORD present while stall=1 is not acted on until stall drops.
- Outputs never X after the first reset edge. No output depends combinationally on stall/jump/branch.

Test Plan:
1. Reset then run; mem[0..3]=32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444 -> direinstru 0,1,2,3 on successive cycles; instr_out/pc_out (0x11111111,0), (0x22222222,1), (0x33333333,2) one cycle later; valid_out=1; pc_plus1=pc_out+1.
2. Stall for 3 cycles while direinstru=2 -> direinstru stays 2, instr_out stays 0x22222222, pc_out stays 1; on release, next edge gives instr_out=0x33333333, direinstru=3.
3. jump=1, jump_target=6'd40 with branch_taken=1, branch_target=6'd10, same edge, stall=1 -> next cycle direinstru=40, valid_out=0, instr_out=0; following edge instr_out=mem[40], pc_out=40.
4. Branch to 63, mem[63]=32'hA5A5A5A5 -> instr_out=0xA5A5A5A5 with pc_out=63, direinstru wraps to 0, pc_plus1=0.
5. mem[5]=32'hFFFFFFFF -> instr_out=0xFFFFFFFF with valid_out=1 and pc_out=5; next edge valid_out=0, halted=1, direinstru stays 5; jump pulses ignored; rst_n=0 one edge -> halted=0, direinstru=0.
6. rst_n=0 asserted mid-run at direinstru=17 with stall=1 -> after that edge pc=0, valid_out=0, instr_out=0, pc_out=0. A glitch on rst_n between edges has no effect (synchronous).

Source files
------------

// File: rtl/unidad_busqueda.sv
// Instruction-fetch unit: owns the PC, addresses a combinational instruction
// memory and registers the returned word for decode. Supports stall, redirect and halt.
module unidad_busqueda #(
   parameter int                 ADDR_W    = 6,
   parameter int                 DATA_W    = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
   parameter logic [DATA_W-1:0]  HALT_WORD = '1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              jump,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   output logic [ADDR_W-1:0] direinstru,
   input  logic [DATA_W-1:0] instru,
   output logic [DATA_W-1:0] instr_out,
   output logic [ADDR_W-1:0] pc_out,
   output logic [ADDR_W-1:0] pc_plus1,
   output logic              valid_out,
   output logic              halted
);

   typedef enum logic {FETCH, HALT} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0] pc_out_q, pc_out_d;
   logic              valid_q, valid_d;
   logic              halted_q, halted_d;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      pc_out_d = pc_out_q;
      valid_d  = valid_q;
      halted_d = halted_q;
      case (state_q)
         FETCH: begin
            // Redirect overrides stall so the wrong-path word is flushed immediately.
            if (jump || branch_taken) begin
               pc_d    = jump ? jump_target : branch_target;
               instr_d = '0;
               valid_d = 1'b0;
            end else if (!stall) begin
               instr_d  = instru;
               pc_out_d = pc_q;
               valid_d  = 1'b1;
               if (instru == HALT_WORD) state_d = HALT;
               else                     pc_d    = pc_q + ADDR_W'(1);
            end
         end
         HALT: begin
            instr_d  = '0;
            valid_d  = 1'b0;
            halted_d = 1'b1;
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= FETCH;
         pc_q     <= RESET_PC;
         instr_q  <= '0;
         pc_out_q <= '0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         pc_out_q <= pc_out_d;
         valid_q  <= valid_d;
         halted_q <= halted_d;
      end
   end

   assign direinstru = pc_q;
   assign instr_out  = instr_q;
   assign pc_out     = pc_out_q;
   assign pc_plus1   = pc_out_q + ADDR_W'(1);
   assign valid_out  = valid_q;
   assign halted     = halted_q;

endmodule
